// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command bytes and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_SHIFT,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  // 100 us inhibit and 20 ms stall limit at 50 MHz
  localparam int PS2_INHIBIT_CYCLES = 5000;
  localparam int PS2_TIMEOUT_CYCLES = 1_000_000;
  localparam int PS2_CNT_W          = 20;

  // Shift order after the start bit: d0..d7, odd parity, stop.
  function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pins plus a registered
// falling-edge pulse on the clock (3 CLK cycles from pin to pulse).
module ps2_line_sync (
  input  logic CLK,
  input  logic RST,
  input  logic ps2c_in,
  input  logic ps2d_in,
  output logic ps2c_sync,
  output logic ps2d_sync,
  output logic ps2c_fall
);

  logic [1:0] c_pipe_reg;
  logic [1:0] d_pipe_reg;
  logic       c_prev_reg;
  logic       fall_reg;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      c_pipe_reg <= 2'b11;
      d_pipe_reg <= 2'b11;
      c_prev_reg <= 1'b1;
      fall_reg   <= 1'b0;
    end else begin
      c_pipe_reg <= {c_pipe_reg[0], ps2c_in};
      d_pipe_reg <= {d_pipe_reg[0], ps2d_in};
      c_prev_reg <= c_pipe_reg[1];
      fall_reg   <= c_prev_reg & ~c_pipe_reg[1];
    end
  end

  assign ps2c_sync = c_pipe_reg[1];
  assign ps2d_sync = d_pipe_reg[1];
  assign ps2c_fall = fall_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request, shift, ACK check.
// Optional macro PS2_TX_RETRY_EN: resend up to 2 extra times on NACK or timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES,
  parameter int CNT_W          = PS2_CNT_W
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low
);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_t    state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [9:0]       shreg_reg, shreg_next;
  logic [3:0]       idx_reg, idx_next;
  logic             nack_reg, nack_next;
  logic             c_low_reg, c_low_next;
  logic             d_low_reg, d_low_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;
  logic             to_reg, to_next;
  logic             ps2c_sync, ps2d_sync, ps2c_fall;
  logic             timed_out, fail, fail_timeout;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]       retry_reg, retry_next;
`endif

  ps2_line_sync u_sync (
    .CLK       (CLK),
    .RST       (RST),
    .ps2c_in   (ps2c_in),
    .ps2d_in   (ps2d_in),
    .ps2c_sync (ps2c_sync),
    .ps2d_sync (ps2d_sync),
    .ps2c_fall (ps2c_fall)
  );

  assign timed_out = (cnt_reg == TIMEOUT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      shreg_reg <= '0;
      idx_reg   <= '0;
      nack_reg  <= 1'b0;
      c_low_reg <= 1'b0;
      d_low_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      to_reg    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shreg_reg <= shreg_next;
      idx_reg   <= idx_next;
      nack_reg  <= nack_next;
      c_low_reg <= c_low_next;
      d_low_reg <= d_low_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      to_reg    <= to_next;
`ifdef PS2_TX_RETRY_EN
      retry_reg <= retry_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
    shreg_next   = shreg_reg;
    idx_next     = idx_reg;
    nack_next    = nack_reg;
    c_low_next   = c_low_reg;
    d_low_next   = d_low_reg;
    done_next    = 1'b0;
    err_next     = 1'b0;
    to_next      = 1'b0;
    fail         = 1'b0;
    fail_timeout = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_next   = retry_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        c_low_next = 1'b0;
        d_low_next = 1'b0;
        if (tx_start) begin
          shreg_next = ps2_tx_frame(tx_data);
          cnt_next   = '0;
          c_low_next = 1'b1;
          nack_next  = 1'b0;
          state_next = ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
          retry_next = '0;
`endif
        end
      end
      ST_INHIBIT: begin
        c_low_next = 1'b1;
        if (cnt_reg == INHIBIT_LAST) begin
          d_low_next = 1'b1;
          state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        cnt_next   = '0;
        c_low_next = 1'b0;
        idx_next   = '0;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ps2c_fall) begin
          cnt_next   = '0;
          d_low_next = ~shreg_reg[idx_reg];
          idx_next   = idx_reg + 1'b1;
          if (idx_reg == 4'd9) state_next = ST_ACK;
        end else if (timed_out) begin
          fail         = 1'b1;
          fail_timeout = 1'b1;
        end
      end
      ST_ACK: begin
        d_low_next = 1'b0;
        if (ps2c_fall) begin
          cnt_next   = '0;
          nack_next  = ps2d_sync;
          state_next = ST_WAIT_IDLE;
        end else if (timed_out) begin
          fail         = 1'b1;
          fail_timeout = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        c_low_next = 1'b0;
        d_low_next = 1'b0;
        if (ps2c_sync && ps2d_sync) begin
          if (nack_reg) begin
            fail = 1'b1;
          end else begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end else if (timed_out) begin
          fail         = 1'b1;
          fail_timeout = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Failure either restarts the frame from the inhibit phase or ends it.
    if (fail) begin
`ifdef PS2_TX_RETRY_EN
      if (retry_reg != 2'd2) begin
        retry_next = retry_reg + 1'b1;
        cnt_next   = '0;
        c_low_next = 1'b1;
        d_low_next = 1'b0;
        state_next = ST_INHIBIT;
      end else begin
        c_low_next = 1'b0;
        d_low_next = 1'b0;
        err_next   = ~fail_timeout;
        to_next    = fail_timeout;
        state_next = ST_IDLE;
      end
`else
      c_low_next = 1'b0;
      d_low_next = 1'b0;
      err_next   = ~fail_timeout;
      to_next    = fail_timeout;
      state_next = ST_IDLE;
`endif
    end
  end

  assign tx_busy        = (state_reg != ST_IDLE);
  assign tx_done        = done_reg;
  assign tx_ack_err     = err_reg;
  assign tx_timeout     = to_reg;
  assign ps2c_drive_low = c_low_reg;
  assign ps2d_drive_low = d_low_reg;

endmodule
